// File: rtl/jtbubl_pkg.sv
// Shared definitions for the Bubble Bobble ROM slot requester: FSM encoding
// and line-geometry helpers.
package jtbubl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_ACK  = 2'd1,
    ST_WAIT_DATA = 2'd2
  } state_t;

  // Number of address bits selecting a DW lane inside a 32-bit line.
  function automatic int sel_w(input int dw);
    return (dw == 8) ? 2 : (dw == 16) ? 1 : 0;
  endfunction

  // Same, but never zero so select vectors can always be declared.
  function automatic int sel_vw(input int dw);
    return (sel_w(dw) == 0) ? 1 : sel_w(dw);
  endfunction

endpackage

// File: rtl/jtbubl_romslot_line.sv
// One cache entry: valid/tag/data registers, tag compare and lane mux.
module jtbubl_romslot_line
  import jtbubl_pkg::*;
#(
  parameter int TW = 16,
  parameter int DW = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 clr,
  input  logic                 we,
  input  logic [TW-1:0]        wtag,
  input  logic [31:0]          wdata,
  input  logic [TW-1:0]        tag,
  input  logic [sel_vw(DW)-1:0] sel,
  output logic                 hit,
  output logic [DW-1:0]        lane
);

  logic          valid_q, valid_d;
  logic [TW-1:0] tag_q, tag_d;
  logic [31:0]   data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d = 1'b1;
      tag_d   = wtag;
      data_d  = wdata;
    end
    if (clr) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit = valid_q && (tag_q == tag);

  // Lane 0 sits in the low bits: the lower address comes first in the line.
  always_comb begin
    lane = data_q[DW-1:0];
    for (int i = 0; i < 32 / DW; i++) begin
      if (int'(sel) == i) lane = data_q[i*DW +: DW];
    end
  end

endmodule

// File: rtl/jtbubl_romslot.sv
// ROM slot requester with a two-line LRU cache between a CPU ROM bus and the
// SDRAM arbiter. Optional hit/miss counters under JTBUBL_ROMSLOT_STATS_EN.
module jtbubl_romslot
  import jtbubl_pkg::*;
#(
  parameter int          AW     = 18,
  parameter int          DW     = 8,
  parameter logic [21:0] OFFSET = 22'h0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          downloading,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic [DW-1:0] dout,
  output logic          data_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  input  logic          sdram_ack,
  input  logic          data_rdy,
`ifdef JTBUBL_ROMSLOT_STATS_EN
  output logic [15:0]   hit_cnt,
  output logic [15:0]   miss_cnt,
`endif
  input  logic [31:0]   din
);

  localparam int SW   = sel_w(DW);
  localparam int SELW = sel_vw(DW);
  localparam int TW   = AW - SW;

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic [21:0]   saddr_q, saddr_d;
  logic [TW-1:0] ltag_q, ltag_d;
  logic          data_ok_q, data_ok_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          lru_q, lru_d;

  logic [TW-1:0]   tag;
  logic [TW:0]     tag_x2;
  logic [SELW-1:0] lsel;
  logic            hit0, hit1, hit;
  logic [DW-1:0]   lane0, lane1;
  logic            fill, miss_start;

  assign tag    = addr[AW-1:SW];
  assign tag_x2 = {tag, 1'b0};

  generate
    if (SW == 0) begin : g_nosel
      assign lsel = '0;
    end else begin : g_sel
      assign lsel = addr[SW-1:0];
    end
  endgenerate

  jtbubl_romslot_line #(.TW(TW), .DW(DW)) u_line0 (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (downloading),
    .we    (fill & ~lru_q),
    .wtag  (ltag_q),
    .wdata (din),
    .tag   (tag),
    .sel   (lsel),
    .hit   (hit0),
    .lane  (lane0)
  );

  jtbubl_romslot_line #(.TW(TW), .DW(DW)) u_line1 (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (downloading),
    .we    (fill & lru_q),
    .wtag  (ltag_q),
    .wdata (din),
    .tag   (tag),
    .sel   (lsel),
    .hit   (hit1),
    .lane  (lane1)
  );

  assign hit = hit0 | hit1;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    saddr_d    = saddr_q;
    ltag_d     = ltag_q;
    fill       = 1'b0;
    miss_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cs && !hit) begin
          state_d    = ST_WAIT_ACK;
          req_d      = 1'b1;
          saddr_d    = OFFSET + 22'(tag_x2);
          ltag_d     = tag;
          miss_start = 1'b1;
        end
      end
      ST_WAIT_ACK: begin
        // Ack and data in the same cycle complete the fetch directly.
        if (sdram_ack) begin
          req_d = 1'b0;
          if (data_rdy) begin
            fill    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WAIT_DATA;
          end
        end
      end
      ST_WAIT_DATA: begin
        if (data_rdy) begin
          fill    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (downloading) begin
      state_d    = ST_IDLE;
      req_d      = 1'b0;
      fill       = 1'b0;
      miss_start = 1'b0;
    end
  end

  always_comb begin
    data_ok_d = cs & hit & ~downloading;
    dout_d    = dout_q;
    lru_d     = lru_q;
    if (cs && hit) dout_d = hit0 ? lane0 : lane1;
    // lru_q names the entry to replace next; a fill makes its entry MRU.
    if (fill) begin
      lru_d = ~lru_q;
    end else if (cs && hit && !downloading) begin
      lru_d = hit0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      req_q     <= 1'b0;
      saddr_q   <= '0;
      ltag_q    <= '0;
      data_ok_q <= 1'b0;
      dout_q    <= '0;
      lru_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      saddr_q   <= saddr_d;
      ltag_q    <= ltag_d;
      data_ok_q <= data_ok_d;
      dout_q    <= dout_d;
      lru_q     <= lru_d;
    end
  end

  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;
  assign data_ok    = data_ok_q & cs;
  assign dout       = dout_q;

`ifdef JTBUBL_ROMSLOT_STATS_EN
  logic          cs_q, cs_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   hit_cnt_q, hit_cnt_d;
  logic [15:0]   miss_cnt_q, miss_cnt_d;
  logic          hit_evt;

  // A hit is counted once per new access, not once per cycle it is held.
  assign hit_evt = cs & hit & ~downloading & (~cs_q | (addr != addr_q));

  always_comb begin
    cs_d       = cs;
    addr_d     = addr;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (hit_evt && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
    if (miss_start && miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
    if (downloading) begin
      hit_cnt_d  = '0;
      miss_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cs_q       <= 1'b0;
      addr_q     <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      cs_q       <= cs_d;
      addr_q     <= addr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_jtbubl_romslot.sv
// Directed bench for jtbubl_romslot (AW=18, DW=8, OFFSET=0) with a queue of
// expected read data popped whenever the slot reports data_ok.
module tb_jtbubl_romslot;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        downloading = 1'b0;
  logic        cs = 1'b0;
  logic [17:0] addr = '0;
  logic [7:0]  dout;
  logic        data_ok;
  logic        sdram_req;
  logic [21:0] sdram_addr;
  logic        sdram_ack = 1'b0;
  logic        data_rdy = 1'b0;
  logic [31:0] din = '0;
`ifdef JTBUBL_ROMSLOT_STATS_EN
  logic [15:0] hit_cnt, miss_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [7:0] exp_q[$];

  jtbubl_romslot #(.AW(18), .DW(8), .OFFSET(22'h0)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .downloading(downloading),
    .cs         (cs),
    .addr       (addr),
    .dout       (dout),
    .data_ok    (data_ok),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .data_rdy   (data_rdy),
`ifdef JTBUBL_ROMSLOT_STATS_EN
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
`endif
    .din        (din)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", name, obs, exp);
  endtask

  function automatic logic [31:0] line_val(input logic [15:0] t);
    if (t == 16'h0001) return 32'hDDCCBBAA;
    return {~t[7:0], t[7:0] ^ 8'h3C, t[15:8] + 8'h40, t[7:0] + 8'h01};
  endfunction

  function automatic logic [7:0] model_byte(input logic [17:0] a);
    logic [31:0] lv;
    lv = line_val(a[17:2]);
    return lv[8*a[1:0] +: 8];
  endfunction

  function automatic logic [21:0] exp_saddr(input logic [17:0] a);
    logic [16:0] w;
    w = {a[17:2], 1'b0};
    return 22'(w);
  endfunction

  task automatic pop_chk(input string name);
    logic [7:0] e;
    chk({name, "_ok"}, 32'(data_ok), 32'd1);
    chk({name, "_sb"}, 32'(exp_q.size()), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(name, 32'(dout), 32'(e));
    end
  endtask

  // Entered at the negedge where sdram_req is seen; returns at the negedge after the fill edge.
  task automatic serve(input logic [15:0] t, input bit same);
    if (same) begin
      sdram_ack = 1'b1; data_rdy = 1'b1; din = line_val(t);
      tick();
      sdram_ack = 1'b0; data_rdy = 1'b0;
      chk("req_drop", 32'(sdram_req), 32'd0);
    end else begin
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      chk("req_drop", 32'(sdram_req), 32'd0);
      data_rdy = 1'b1; din = line_val(t);
      tick();
      data_rdy = 1'b0;
    end
  endtask

  task automatic access(input logic [17:0] a, input bit exp_hit, input bit same);
    exp_q.push_back(model_byte(a));
    addr = a; cs = 1'b1;
    tick();
    if (exp_hit) begin
      chk("hit_noreq", 32'(sdram_req), 32'd0);
      pop_chk("hit_dout");
    end else begin
      chk("miss_req", 32'(sdram_req), 32'd1);
      chk("miss_addr", 32'(sdram_addr), 32'(exp_saddr(a)));
      serve(a[17:2], same);
      chk("ok_early", 32'(data_ok), 32'd0);
      tick();
      pop_chk("miss_dout");
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_req", 32'(sdram_req), 32'd0);
    chk("rst_saddr", 32'(sdram_addr), 32'd0);
    chk("rst_ok", 32'(data_ok), 32'd0);
    chk("rst_dout", 32'(dout), 32'd0);
    rstn = 1'b1;
    tick();

    // First miss with the reference line; request held until ack.
    exp_q.push_back(8'hBB);
    cs = 1'b1; addr = 18'h00005;
    tick();
    chk("t1_req", 32'(sdram_req), 32'd1);
    chk("t1_saddr", 32'(sdram_addr), 32'h000002);
    tick();
    chk("t1_hold_req", 32'(sdram_req), 32'd1);
    chk("t1_hold_addr", 32'(sdram_addr), 32'h000002);
    serve(16'h0001, 1'b0);
    chk("t1_ok_early", 32'(data_ok), 32'd0);
    tick();
    pop_chk("t1_dout");

    exp_q.push_back(8'hCC);
    addr = 18'h00006;
    tick();
    chk("t2_noreq", 32'(sdram_req), 32'd0);
    pop_chk("t2_dout");

    // LRU replacement: A, B, touch A, C evicts B.
    access(18'h00040, 1'b0, 1'b0);
    access(18'h00080, 1'b0, 1'b0);
    access(18'h00041, 1'b1, 1'b0);
    access(18'h000C0, 1'b0, 1'b1);
    access(18'h00042, 1'b1, 1'b0);
    access(18'h00083, 1'b0, 1'b0);

    cs = 1'b0;
    #1 chk("ok_cs_drop", 32'(data_ok), 32'd0);
    cs = 1'b1;
    #1 chk("ok_cs_back", 32'(data_ok), 32'd1);
    @(negedge clk);

    // Address moves while the fetch is in WAIT_DATA.
    exp_q.push_back(model_byte(18'h00200));
    addr = 18'h00100;
    tick();
    chk("mf_req", 32'(sdram_req), 32'd1);
    chk("mf_saddr", 32'(sdram_addr), 32'h000080);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    addr = 18'h00200;
    data_rdy = 1'b1; din = line_val(16'h0040);
    tick();
    data_rdy = 1'b0;
    chk("mf_ok_stale", 32'(data_ok), 32'd0);
    chk("mf_idle_noreq", 32'(sdram_req), 32'd0);
    tick();
    chk("mf_ok_stale2", 32'(data_ok), 32'd0);
    chk("mf_req2", 32'(sdram_req), 32'd1);
    chk("mf_saddr2", 32'(sdram_addr), 32'h000100);
    serve(16'h0080, 1'b0);
    chk("mf_ok_early", 32'(data_ok), 32'd0);
    tick();
    pop_chk("mf_dout");
    access(18'h00101, 1'b1, 1'b0);

    // Download aborts a pending request and flushes the cache.
    addr = 18'h00300;
    tick();
    chk("dl_req", 32'(sdram_req), 32'd1);
    downloading = 1'b1;
    tick();
    chk("dl_req_drop", 32'(sdram_req), 32'd0);
    chk("dl_ok", 32'(data_ok), 32'd0);
    tick();
    chk("dl_blocked", 32'(sdram_req), 32'd0);
    downloading = 1'b0;
    cs = 1'b0;
    data_rdy = 1'b1; din = 32'hFFFF_FFFF;
    tick();
    data_rdy = 1'b0;
    access(18'h00300, 1'b0, 1'b0);
    access(18'h00101, 1'b0, 1'b0);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

`ifdef JTBUBL_ROMSLOT_STATS_EN
    cs = 1'b0; rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    access(18'h00400, 1'b0, 1'b0);
    access(18'h00401, 1'b1, 1'b0);
    access(18'h00402, 1'b1, 1'b0);
    access(18'h00500, 1'b0, 1'b0);
    access(18'h00600, 1'b0, 1'b0);
    access(18'h00501, 1'b1, 1'b0);
    access(18'h00601, 1'b1, 1'b0);
    cs = 1'b0;
    tick();
    access(18'h00602, 1'b1, 1'b0);
    chk("st_hit", 32'(hit_cnt), 32'd5);
    chk("st_miss", 32'(miss_cnt), 32'd3);
    rstn = 1'b0;
    tick();
    chk("st_hit_rst", 32'(hit_cnt), 32'd0);
    chk("st_miss_rst", 32'(miss_cnt), 32'd0);
    rstn = 1'b1;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/jtbubl_romslot.md
Name: jtbubl_romslot

Overview:
- Single ROM slot requester with a two-line cache.
- It sits between one CPU ROM bus (main, sub, MCU or sound) and the SDRAM slot arbiter that feeds jtbubl_game's ROM data paths.
- It converts addr/cs into 32-bit SDRAM fetches, keeps the two most recent lines, and returns DW-wide data with an ok flag.
- It replaces the per-slot request logic for the Bubble Bobble/Tokio CPUs.

Parameters:
- AW, 18, CPU address width in DW-sized units.
- DW, 8, data width; legal values 8, 16, 32.
- OFFSET, 22'h0, SDRAM 16-bit word offset added to every request.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- downloading  in  1  ROM download in progress; invalidates cache and blocks requests.
- cs  in  1  CPU ROM chip select.
- addr  in  AW  CPU address.
- dout  out  DW  read data.
- data_ok  out  1  dout valid for current addr.
- sdram_req  out  1  fetch request to arbiter.
- sdram_addr  out  22  16-bit word address of fetch.
- sdram_ack  in  1  arbiter accepted request (1-cycle pulse).
- data_rdy  in  1  din valid (1-cycle pulse).
- din  in  32  fetched line, low halfword = lower address.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, rstn.
- Line geometry:
  - DW=8: line tag = addr[AW-1:2], byte select addr[1:0].
  - DW=16: tag = addr[AW-1:1], select addr[0].
  - DW=32: tag = addr.
  - sdram_addr = OFFSET + {tag,1'b0}, 22-bit modular add with wrap ignored.
- Cache: two entries {valid, tag, data[31:0]} plus 1-bit LRU pointer. Hit = valid & tag match on either entry.
- Hit path:
  - cs high and hit at edge n → data_ok=1 and dout=selected lane at edge n+1; the hitting entry becomes MRU.
  - data_ok is registered and qualified combinationally with cs, so it drops in the same cycle cs falls.
  - A change of addr clears data_ok on the next edge unless the new address also hits.
- FSM:
  - IDLE: cs & miss & ~downloading → WAIT_ACK, sdram_req=1, sdram_addr latched from the tag.
  - WAIT_ACK: hold sdram_req and sdram_addr stable until sdram_ack, then sdram_req=0 on the next edge → WAIT_DATA.
  - WAIT_DATA: on data_rdy, write din into the LRU entry (valid=1, tag=latched tag), make it MRU → IDLE.
    - data_ok rises the following edge if addr still matches.
    - If addr changed mid-fetch, the fill still completes, then the new addr is evaluated from IDLE. Minimum miss latency = 1 cycle beyond data_rdy.
  - sdram_ack and data_rdy in the same cycle while in WAIT_ACK: treat as ack then fill; go directly to IDLE with the entry written.
  - data_rdy outside WAIT_DATA is ignored.
  - cs low during WAIT_ACK or WAIT_DATA: the fetch continues to completion (no abort, arbiter protocol intact).
- Downloading:
  - While high, both valid bits clear every cycle, data_ok=0, sdram_req=0.
  - If asserted mid-fetch, the FSM returns to IDLE immediately and the pending request is dropped.
- Reset values: sdram_req=0, sdram_addr=0, data_ok=0, dout=0, valid=00, LRU=0, state IDLE.

Optional Feature:
- JTBUBL_ROMSLOT_STATS_EN.
- When defined, adds outputs hit_cnt[15:0] and miss_cnt[15:0]:
  - hit_cnt increments once per cs-rising or addr-change event that hits.
  - miss_cnt increments on each IDLE→WAIT_ACK transition.
  - Both saturate at 16'hFFFF and are cleared by rstn or downloading.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package jtbubl_pkg holds:
  - state encoding constants ST_IDLE, ST_WAIT_ACK, ST_WAIT_DATA;
  - a line-select width function (2/1/0 bits for DW 8/16/32).
- One natural sub-module: jtbubl_romslot_line, holding one entry (valid/tag/data registers, tag compare, lane mux), instantiated twice.

Test Plan:
- Reset, then cs=1, addr=18'h00005, DW=8, OFFSET=22'h0 → sdram_req=1 with sdram_addr=22'h000002; ack; data_rdy with din=32'hDDCCBBAA → dout=8'hBB, data_ok=1 one cycle after data_rdy.
- After the fill, addr=18'h00006 → hit, no sdram_req, dout=8'hCC next cycle.
- Fill tags A then B, access A, then miss on C → C replaces B (LRU); re-access A hits, B misses.
- addr changed from 18'h00100 to 18'h00200 during WAIT_DATA → first fill completes, second request issued with sdram_addr=22'h000100 (tag 18'h80 <<1); data_ok only for 18'h00200 data.
- downloading=1 during WAIT_ACK → sdram_req=0 next cycle, data_ok=0; after downloading=0, a previously cached address misses and is refetched.
- With JTBUBL_ROMSLOT_STATS_EN: 3 misses + 5 hits → miss_cnt=3, hit_cnt=5; rstn=0 → both 0.
